// File: rtl/axi_arbiter.sv
// Two-requester AXI4 read/write arbiter: IFU (m0) reads and LSU (m1) reads/writes
// share one downstream master port, with one transaction in flight at a time.
module axi_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    // m0: IFU read channel
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic        m0_rlast,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,

    // m1: LSU read channel
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic        m1_rlast,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,

    // m1: LSU write channels
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_awaddr,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    output logic [1:0]  m1_bresp,

    // Downstream AXI4 master port
    input  logic        io_master_awready,
    output logic        io_master_awvalid,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,
    input  logic        io_master_wready,
    output logic        io_master_wvalid,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,
    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,
    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [31:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } state_e;

    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;  // 1: m1 won the most recent read
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   grant_m1;

    // Only one transaction is ever outstanding, so response IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{io_master_bid, io_master_rid};

    always_comb begin
        if (m0_arvalid && m1_arvalid) begin
            grant_m1 = RR_EN ? !last_grant_q : 1'b1;
        end else begin
            grant_m1 = m1_arvalid;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (m1_awvalid) begin
                    state_d = WR1;
                end else if (m0_arvalid || m1_arvalid) begin
                    state_d      = grant_m1 ? RD1 : RD0;
                    last_grant_d = grant_m1;
                end
            end
            RD0, RD1: begin
                if (io_master_rvalid && io_master_rready && io_master_rlast) state_d = IDLE;
            end
            WR1: begin
                if (io_master_bvalid && io_master_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Address/data handshakes are remembered so a requester re-raising valid
        // mid-transaction is not forwarded a second time.
        ar_done_d = (state_q != IDLE) && (ar_done_q || (io_master_arvalid && io_master_arready));
        aw_done_d = (state_q != IDLE) && (aw_done_q || (io_master_awvalid && io_master_awready));
        w_done_d  = (state_q != IDLE) && (w_done_q  || (io_master_wvalid  && io_master_wready));
    end

    // NOTE: every output is defaulted before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        m0_arready        = 1'b0;
        m0_rvalid         = 1'b0;
        m0_rlast          = 1'b0;
        m0_rdata          = '0;
        m0_rresp          = '0;
        m1_arready        = 1'b0;
        m1_rvalid         = 1'b0;
        m1_rlast          = 1'b0;
        m1_rdata          = '0;
        m1_rresp          = '0;
        m1_awready        = 1'b0;
        m1_wready         = 1'b0;
        m1_bvalid         = 1'b0;
        m1_bresp          = '0;
        io_master_awvalid = 1'b0;
        io_master_awaddr  = '0;
        io_master_awid    = '0;
        io_master_awlen   = '0;
        io_master_awsize  = '0;
        io_master_awburst = '0;
        io_master_wvalid  = 1'b0;
        io_master_wdata   = '0;
        io_master_wstrb   = '0;
        io_master_wlast   = 1'b0;
        io_master_bready  = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_araddr  = '0;
        io_master_arid    = '0;
        io_master_arlen   = '0;
        io_master_arsize  = '0;
        io_master_arburst = '0;
        io_master_rready  = 1'b0;

        unique case (state_q)
            RD0: begin
                io_master_arvalid = m0_arvalid && !ar_done_q;
                io_master_araddr  = m0_araddr;
                io_master_arlen   = m0_arlen;
                io_master_arsize  = SIZE_4B;
                io_master_arburst = BURST_INCR;
                m0_arready        = io_master_arready && !ar_done_q;
                m0_rvalid         = io_master_rvalid;
                m0_rlast          = io_master_rlast;
                m0_rdata          = io_master_rdata;
                m0_rresp          = io_master_rresp;
                io_master_rready  = m0_rready;
            end
            RD1: begin
                io_master_arvalid = m1_arvalid && !ar_done_q;
                io_master_araddr  = m1_araddr;
                io_master_arlen   = m1_arlen;
                io_master_arsize  = SIZE_4B;
                io_master_arburst = BURST_INCR;
                m1_arready        = io_master_arready && !ar_done_q;
                m1_rvalid         = io_master_rvalid;
                m1_rlast          = io_master_rlast;
                m1_rdata          = io_master_rdata;
                m1_rresp          = io_master_rresp;
                io_master_rready  = m1_rready;
            end
            WR1: begin
                io_master_awvalid = m1_awvalid && !aw_done_q;
                io_master_awaddr  = m1_awaddr;
                io_master_awsize  = SIZE_4B;
                io_master_awburst = BURST_INCR;
                m1_awready        = io_master_awready && !aw_done_q;
                io_master_wvalid  = m1_wvalid && !w_done_q;
                io_master_wdata   = m1_wdata;
                io_master_wstrb   = m1_wstrb;
                io_master_wlast   = 1'b1;
                m1_wready         = io_master_wready && !w_done_q;
                m1_bvalid         = io_master_bvalid;
                m1_bresp          = io_master_bresp;
                io_master_bready  = m1_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: one round-robin instance and one fixed-priority
// instance share stimulus, each held in reset while the other is exercised.
module tb_axi_arbiter;

    logic clock = 1'b0;
    logic reset, reset_f;
    always #5 clock = ~clock;

    logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
    logic [31:0] m0_araddr, m1_araddr;
    logic [7:0]  m0_arlen, m1_arlen;
    logic        m1_awvalid, m1_wvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        io_master_awready, io_master_wready, io_master_bvalid, io_master_arready;
    logic        io_master_rvalid, io_master_rlast;
    logic [1:0]  io_master_bresp, io_master_rresp;
    logic [3:0]  io_master_bid, io_master_rid;
    logic [31:0] io_master_rdata;

    // Round-robin instance outputs
    logic        m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic        m1_awready, m1_wready, m1_bvalid;
    logic        io_master_awvalid, io_master_wvalid, io_master_wlast, io_master_bready;
    logic        io_master_arvalid, io_master_rready;
    logic [31:0] io_master_awaddr, io_master_wdata, io_master_araddr;
    logic [3:0]  io_master_awid, io_master_wstrb, io_master_arid;
    logic [7:0]  io_master_awlen, io_master_arlen;
    logic [2:0]  io_master_awsize, io_master_arsize;
    logic [1:0]  io_master_awburst, io_master_arburst;

    // Fixed-priority instance outputs
    logic        f_m0_arready, f_m0_rvalid, f_m0_rlast, f_m1_arready, f_m1_rvalid, f_m1_rlast;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic [1:0]  f_m0_rresp, f_m1_rresp, f_m1_bresp;
    logic        f_m1_awready, f_m1_wready, f_m1_bvalid;
    logic        f_awvalid, f_wvalid, f_wlast, f_bready, f_arvalid, f_rready;
    logic [31:0] f_awaddr, f_wdata, f_araddr;
    logic [3:0]  f_awid, f_wstrb, f_arid;
    logic [7:0]  f_awlen, f_arlen;
    logic [2:0]  f_awsize, f_arsize;
    logic [1:0]  f_awburst, f_arburst;

    axi_arbiter #(.RR_EN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rlast(m0_rlast), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rlast(m1_rlast), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
        .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid), .io_master_awlen(io_master_awlen),
        .io_master_awsize(io_master_awsize), .io_master_awburst(io_master_awburst),
        .io_master_wready(io_master_wready), .io_master_wvalid(io_master_wvalid), .io_master_wdata(io_master_wdata),
        .io_master_wstrb(io_master_wstrb), .io_master_wlast(io_master_wlast),
        .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
        .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
        .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen),
        .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
        .io_master_rready(io_master_rready), .io_master_rvalid(io_master_rvalid), .io_master_rresp(io_master_rresp),
        .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid)
    );

    axi_arbiter #(.RR_EN(1'b0)) dut_fix (
        .clock(clock), .reset(reset_f),
        .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready), .m0_rlast(f_m0_rlast), .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready), .m1_rlast(f_m1_rlast), .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(f_m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(f_m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(f_m1_bvalid), .m1_bready(m1_bready), .m1_bresp(f_m1_bresp),
        .io_master_awready(io_master_awready), .io_master_awvalid(f_awvalid),
        .io_master_awaddr(f_awaddr), .io_master_awid(f_awid), .io_master_awlen(f_awlen),
        .io_master_awsize(f_awsize), .io_master_awburst(f_awburst),
        .io_master_wready(io_master_wready), .io_master_wvalid(f_wvalid), .io_master_wdata(f_wdata),
        .io_master_wstrb(f_wstrb), .io_master_wlast(f_wlast),
        .io_master_bready(f_bready), .io_master_bvalid(io_master_bvalid),
        .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
        .io_master_arready(io_master_arready), .io_master_arvalid(f_arvalid),
        .io_master_araddr(f_araddr), .io_master_arid(f_arid), .io_master_arlen(f_arlen),
        .io_master_arsize(f_arsize), .io_master_arburst(f_arburst),
        .io_master_rready(f_rready), .io_master_rvalid(io_master_rvalid), .io_master_rresp(io_master_rresp),
        .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered one cycle after the grant edge (DUT already in RDm); runs AR and all beats.
    task automatic serve_read(input int m, input logic [31:0] addr, input logic [7:0] len, input int err_beat);
        #1;
        check("ar_valid", io_master_arvalid, 1);
        check("ar_addr", io_master_araddr, addr);
        check("ar_len", io_master_arlen, len);
        check("ar_size", io_master_arsize, 3'b010);
        check("ar_burst", io_master_arburst, 2'b01);
        io_master_arready = 1'b1;
        #1;
        check("ar_ready_sel", (m == 0) ? m0_arready : m1_arready, 1);
        check("ar_ready_other", (m == 0) ? m1_arready : m0_arready, 0);
        tick();
        io_master_arready = 1'b0;
        if (m == 0) m0_arvalid = 1'b0;
        else        m1_arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            io_master_rvalid = 1'b1;
            io_master_rdata  = addr + i;
            io_master_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            io_master_rlast  = (i == int'(len));
            #1;
            check("r_valid", (m == 0) ? m0_rvalid : m1_rvalid, 1);
            check("r_data", (m == 0) ? m0_rdata : m1_rdata, addr + i);
            check("r_resp", (m == 0) ? m0_rresp : m1_rresp, (i == err_beat) ? 2'b10 : 2'b00);
            check("r_last", (m == 0) ? m0_rlast : m1_rlast, i == int'(len));
            check("r_other", (m == 0) ? m1_rvalid : m0_rvalid, 0);
            check("r_ready", io_master_rready, 1);
            tick();
        end
        io_master_rvalid = 1'b0;
        io_master_rlast  = 1'b0;
        io_master_rresp  = 2'b00;
    endtask

    initial begin
        reset = 1'b1; reset_f = 1'b1;
        {m0_arvalid, m1_arvalid, m1_awvalid, m1_wvalid} = '0;
        m0_araddr = '0; m1_araddr = '0; m0_arlen = '0; m1_arlen = '0;
        m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0;
        m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
        {io_master_awready, io_master_wready, io_master_bvalid, io_master_arready} = '0;
        {io_master_rvalid, io_master_rlast} = '0;
        io_master_bresp = '0; io_master_rresp = '0; io_master_bid = '0; io_master_rid = '0;
        io_master_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_arvalid", io_master_arvalid, 0);
        check("rst_awvalid", io_master_awvalid, 0);
        check("rst_wvalid", io_master_wvalid, 0);
        check("rst_rready", io_master_rready, 0);
        check("rst_bready", io_master_bready, 0);
        check("rst_m1_bvalid", m1_bvalid, 0);

        // Lone m0 burst of four beats
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m0_arlen = 8'd3;
        #1;
        check("ar_latency", io_master_arvalid, 0);
        tick();
        serve_read(0, 32'h8000_0000, 8'd3, -1);
        #1;
        check("idle_after_rd_arvalid", io_master_arvalid, 0);
        check("idle_after_rd_rready", io_master_rready, 0);

        // Requester drops arvalid before the handshake: grant is kept
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0100; m0_arlen = 8'd0;
        tick();
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_0200; m1_arlen = 8'd0;
        tick();
        io_master_rvalid = 1'b1; io_master_rlast = 1'b1; io_master_rdata = 32'h55;
        #1;
        check("hold_m0_rvalid", m0_rvalid, 1);
        check("hold_m1_arready", m1_arready, 0);
        tick();
        io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
        tick();
        serve_read(1, 32'h8000_0200, 8'd0, -1);

        // m1 write wins over a pending m0 read
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0040; m0_arlen = 8'd0;
        m1_awvalid = 1'b1; m1_awaddr = 32'ha000_03f8;
        m1_wvalid = 1'b1; m1_wdata = 32'h41; m1_wstrb = 4'b0001;
        #1;
        check("aw_latency", io_master_awvalid, 0);
        tick();
        check("aw_valid", io_master_awvalid, 1);
        check("aw_addr", io_master_awaddr, 32'ha000_03f8);
        check("aw_len", io_master_awlen, 0);
        check("aw_size", io_master_awsize, 3'b010);
        check("aw_burst", io_master_awburst, 2'b01);
        check("w_valid", io_master_wvalid, 1);
        check("w_data", io_master_wdata, 32'h41);
        check("w_strb", io_master_wstrb, 4'b0001);
        check("w_last", io_master_wlast, 1);
        check("wr_no_ar", io_master_arvalid, 0);
        check("wr_m0_arready", m0_arready, 0);
        io_master_awready = 1'b1; io_master_wready = 1'b1;
        #1;
        check("m1_awready", m1_awready, 1);
        check("m1_wready", m1_wready, 1);
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        io_master_awready = 1'b0; io_master_wready = 1'b0;
        io_master_bvalid = 1'b1;
        #1;
        check("m1_bvalid", m1_bvalid, 1);
        check("b_ready", io_master_bready, 1);
        check("b_phase_no_ar", io_master_arvalid, 0);
        tick();
        io_master_bvalid = 1'b0;
        #1;
        check("post_b_idle_ar", io_master_arvalid, 0);
        tick();
        serve_read(0, 32'h8000_0040, 8'd0, -1);

        // SLVERR on beat 2 of 4 is passed through, burst completes
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0800; m0_arlen = 8'd3;
        tick();
        serve_read(0, 32'h8000_0800, 8'd3, 1);
        #1;
        check("err_idle_rready", io_master_rready, 0);

        // Reset during beat 2 of an m0 burst
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_3000; m0_arlen = 8'd3;
        tick();
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0; m0_arvalid = 1'b0;
        io_master_rvalid = 1'b1; io_master_rdata = 32'h1;
        tick();
        io_master_rdata = 32'h2;
        reset = 1'b1;
        tick();
        check("rstmid_m0_rvalid", m0_rvalid, 0);
        check("rstmid_rready", io_master_rready, 0);
        check("rstmid_arvalid", io_master_arvalid, 0);
        reset = 1'b0; io_master_rvalid = 1'b0;
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_4000; m1_arlen = 8'd1;
        #1;
        check("rstmid_new_latency", io_master_arvalid, 0);
        tick();
        serve_read(1, 32'h8000_4000, 8'd1, -1);

        // Round-robin: fresh reset favours m1, then alternates
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_1000; m0_arlen = 8'd1;
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_2000; m1_arlen = 8'd1;
        tick();
        serve_read(1, 32'h8000_2000, 8'd1, -1);
        tick();
        serve_read(0, 32'h8000_1000, 8'd1, -1);
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_2100; m1_arlen = 8'd0;
        tick();
        serve_read(1, 32'h8000_2100, 8'd0, -1);
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_1200; m0_arlen = 8'd0;
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_2200; m1_arlen = 8'd0;
        tick();
        serve_read(0, 32'h8000_1200, 8'd0, -1);
        tick();
        serve_read(1, 32'h8000_2200, 8'd0, -1);

        // Fixed priority: m1 wins every round while held
        reset = 1'b1; reset_f = 1'b0;
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_5000; m0_arlen = 8'd0;
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_6000; m1_arlen = 8'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fix_arvalid", f_arvalid, 1);
            check("fix_araddr", f_araddr, 32'h8000_6000);
            io_master_arready = 1'b1;
            #1;
            check("fix_m1_arready", f_m1_arready, 1);
            check("fix_m0_arready", f_m0_arready, 0);
            tick();
            io_master_arready = 1'b0;
            io_master_rvalid = 1'b1; io_master_rlast = 1'b1;
            #1;
            check("fix_m1_rvalid", f_m1_rvalid, 1);
            check("fix_m0_rvalid", f_m0_rvalid, 0);
            tick();
            io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
